// File: rtl/mapu_arbiter.sv
// Round-robin, whole-job arbiter that lends one mapu_top to NUM_REQ requesters.
// A job is an op, six input rows streamed in, then three result rows streamed back.
module mapu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            i_req_vld,
  input  logic [2*NUM_REQ-1:0]          i_req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_r0,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_r1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_r2,
  output logic [NUM_REQ-1:0]            o_req_rdy,
  output logic [NUM_REQ-1:0]            o_rsp_vld,
  input  logic [NUM_REQ-1:0]            i_rsp_rdy,
  output logic [DATA_WIDTH-1:0]         o_rsp_r0,
  output logic [DATA_WIDTH-1:0]         o_rsp_r1,
  output logic [DATA_WIDTH-1:0]         o_rsp_r2,
  output logic                          o_rsp_of,
  output logic [NUM_REQ-1:0]            o_err,
  output logic                          o_apu_en,
  output logic [1:0]                    o_apu_op,
  output logic                          o_apu_vld,
  output logic [DATA_WIDTH-1:0]         o_apu_r0,
  output logic [DATA_WIDTH-1:0]         o_apu_r1,
  output logic [DATA_WIDTH-1:0]         o_apu_r2,
  input  logic                          i_apu_rdy,
  output logic                          o_apu_rdy,
  input  logic                          i_apu_vld,
  input  logic [DATA_WIDTH-1:0]         i_apu_r0,
  input  logic [DATA_WIDTH-1:0]         i_apu_r1,
  input  logic [DATA_WIDTH-1:0]         i_apu_r2,
  input  logic                          i_apu_of
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d, rr_q, rr_d, pick, idx, grant_inc;
  logic [GW:0]         sum;
  logic                found;
  logic [1:0]          op_q, op_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [NUM_REQ-1:0]  err_q, err_d;

  logic [DATA_WIDTH-1:0] req_r0 [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_r1 [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_r2 [NUM_REQ];
  logic [1:0]            req_op [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_r0[k] = i_req_r0[k*DATA_WIDTH +: DATA_WIDTH];
    assign req_r1[k] = i_req_r1[k*DATA_WIDTH +: DATA_WIDTH];
    assign req_r2[k] = i_req_r2[k*DATA_WIDTH +: DATA_WIDTH];
    assign req_op[k] = i_req_op[2*k +: 2];
  end

  // Search for the first pending requester starting at the rr pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_q} + (GW+1)'(i);
      if (sum >= (GW+1)'(NUM_REQ)) sum = sum - (GW+1)'(NUM_REQ);
      idx = sum[GW-1:0];
      if (!found && i_req_vld[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign grant_inc = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
  assign o_err     = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  // The granted requester is steered straight through to/from the MAPU; everyone else sees zeros.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    err_d     = '0;
    o_req_rdy = '0;
    o_rsp_vld = '0;
    o_rsp_r0  = '0;
    o_rsp_r1  = '0;
    o_rsp_r2  = '0;
    o_rsp_of  = 1'b0;
    o_apu_en  = 1'b0;
    o_apu_op  = '0;
    o_apu_vld = 1'b0;
    o_apu_r0  = '0;
    o_apu_r1  = '0;
    o_apu_r2  = '0;
    o_apu_rdy = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          op_d    = req_op[pick];
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        o_apu_vld          = i_req_vld[grant_q];
        o_apu_r0           = req_r0[grant_q];
        o_apu_r1           = req_r1[grant_q];
        o_apu_r2           = req_r2[grant_q];
        o_req_rdy[grant_q] = i_apu_rdy;
        if (i_req_vld[grant_q] && i_apu_rdy) begin
          if (cnt_q == 3'd5) begin
            cnt_d   = '0;
            timer_d = '0;
            state_d = EXEC;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      EXEC: begin
        o_apu_en = 1'b1;
        o_apu_op = op_q;
        if (i_apu_vld) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d[grant_q] = 1'b1;
          rr_d           = grant_inc;
          state_d        = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DRAIN: begin
        o_apu_en           = 1'b1;
        o_apu_op           = op_q;
        o_rsp_vld[grant_q] = i_apu_vld;
        o_rsp_r0           = i_apu_r0;
        o_rsp_r1           = i_apu_r1;
        o_rsp_r2           = i_apu_r2;
        o_rsp_of           = i_apu_of;
        o_apu_rdy          = i_rsp_rdy[grant_q];
        if (i_apu_vld && i_rsp_rdy[grant_q]) begin
          if (cnt_q == 3'd2) begin
            cnt_d   = '0;
            rr_d    = grant_inc;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mapu_arbiter.sv
// Bench for mapu_arbiter: two requester drivers, a stand-in MAPU, and a scoreboard
// monitor that checks every delivered result row and every timeout pulse.
module tb_mapu_arbiter;
  localparam int DW = 32;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   i_req_vld;
  logic [2*NR-1:0] i_req_op;
  logic [NR*DW-1:0] i_req_r0, i_req_r1, i_req_r2;
  logic [NR-1:0]   o_req_rdy, o_rsp_vld, i_rsp_rdy, o_err;
  logic [DW-1:0]   o_rsp_r0, o_rsp_r1, o_rsp_r2;
  logic            o_rsp_of, o_apu_en, o_apu_vld, i_apu_rdy, o_apu_rdy, i_apu_vld, i_apu_of;
  logic [1:0]      o_apu_op;
  logic [DW-1:0]   o_apu_r0, o_apu_r1, o_apu_r2, i_apu_r0, i_apu_r1, i_apu_r2;

  mapu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req_vld(i_req_vld), .i_req_op(i_req_op),
    .i_req_r0(i_req_r0), .i_req_r1(i_req_r1), .i_req_r2(i_req_r2),
    .o_req_rdy(o_req_rdy), .o_rsp_vld(o_rsp_vld), .i_rsp_rdy(i_rsp_rdy),
    .o_rsp_r0(o_rsp_r0), .o_rsp_r1(o_rsp_r1), .o_rsp_r2(o_rsp_r2), .o_rsp_of(o_rsp_of),
    .o_err(o_err), .o_apu_en(o_apu_en), .o_apu_op(o_apu_op), .o_apu_vld(o_apu_vld),
    .o_apu_r0(o_apu_r0), .o_apu_r1(o_apu_r1), .o_apu_r2(o_apu_r2),
    .i_apu_rdy(i_apu_rdy), .o_apu_rdy(o_apu_rdy), .i_apu_vld(i_apu_vld),
    .i_apu_r0(i_apu_r0), .i_apu_r1(i_apu_r1), .i_apu_r2(i_apu_r2), .i_apu_of(i_apu_of)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] op; logic [31:0] e0, e1, e2; } row_t;
  typedef struct { int k; logic [31:0] r0, r1, r2; logic of; } exp_t;

  row_t        rq0[$], rq1[$];
  exp_t        exp_q[$];
  logic [1:0]  err_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          toggle_mode = 1'b0;
  bit          mute = 1'b0;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int k, input logic [31:0] r0, r1, r2, input logic of);
    exp_t e;
    e.k = k; e.r0 = r0; e.r1 = r1; e.r2 = r2; e.of = of;
    exp_q.push_back(e);
  endtask

  // Rows 0..2 form operand A, rows 3..5 operand B; element e of row j is base + step*(3j+e).
  task automatic apply_stimulus(input int k, input logic [1:0] op,
                                input logic [31:0] a, sa, b, sb);
    row_t r;
    logic [31:0] base, s;
    for (int j = 0; j < 6; j++) begin
      base = (j < 3) ? a + sa * 32'(3*j) : b + sb * 32'(3*(j-3));
      s    = (j < 3) ? sa : sb;
      r.op = op; r.e0 = base; r.e1 = base + s; r.e2 = base + 2*s;
      if (k == 0) rq0.push_back(r); else rq1.push_back(r);
    end
  endtask

  task automatic wait_done(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && err_q.size() == 0 && rq0.size() == 0 && rq1.size() == 0)
        done = 1'b1;
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (!done) begin
      miscompares++;
      $display("[TB] FAIL wait_done: got pending=%0d, expected 0", exp_q.size() + err_q.size());
      exp_q.delete(); err_q.delete(); rq0.delete(); rq1.delete();
    end
  endtask

  // Requester drivers: present the head row of each queue, pop on handshake.
  initial begin
    bit f0, f1, phase;
    phase = 1'b0;
    i_req_vld = '0; i_req_op = '0; i_req_r0 = '0; i_req_r1 = '0; i_req_r2 = '0;
    i_rsp_rdy = '1;
    forever begin
      @(negedge clk);
      f0 = i_req_vld[0] && o_req_rdy[0];
      f1 = i_req_vld[1] && o_req_rdy[1];
      @(posedge clk); #1;
      if (f0 && rq0.size() > 0) void'(rq0.pop_front());
      if (f1 && rq1.size() > 0) void'(rq1.pop_front());
      i_req_vld[0] = (rq0.size() > 0);
      if (rq0.size() > 0) begin
        i_req_op[1:0] = rq0[0].op; i_req_r0[31:0] = rq0[0].e0;
        i_req_r1[31:0] = rq0[0].e1; i_req_r2[31:0] = rq0[0].e2;
      end
      i_req_vld[1] = (rq1.size() > 0);
      if (rq1.size() > 0) begin
        i_req_op[3:2] = rq1[0].op; i_req_r0[63:32] = rq1[0].e0;
        i_req_r1[63:32] = rq1[0].e1; i_req_r2[63:32] = rq1[0].e2;
      end
      phase = ~phase;
      i_rsp_rdy = toggle_mode ? {NR{phase}} : '1;
    end
  end

  // Stand-in MAPU: absorbs six rows, then after a short latency returns A op B row by row.
  initial begin
    logic [31:0] m [6][3];
    logic [32:0] t [3];
    int in_cnt, out_idx, lat;
    bit have_job, in_f, out_f, en_s, rst_s, of;
    logic [1:0] op_s;
    logic [31:0] c0, c1, c2;
    in_cnt = 0; out_idx = 0; lat = 0; have_job = 0;
    i_apu_rdy = 1'b1; i_apu_vld = 1'b0; i_apu_of = 1'b0;
    i_apu_r0 = '0; i_apu_r1 = '0; i_apu_r2 = '0;
    forever begin
      @(negedge clk);
      in_f = o_apu_vld && i_apu_rdy; out_f = i_apu_vld && o_apu_rdy;
      en_s = o_apu_en; op_s = o_apu_op; rst_s = reset_n;
      c0 = o_apu_r0; c1 = o_apu_r1; c2 = o_apu_r2;
      @(posedge clk); #1;
      if (!rst_s) begin
        in_cnt = 0; out_idx = 0; have_job = 0; i_apu_vld = 1'b0;
      end else begin
        if (in_f) begin
          m[in_cnt][0] = c0; m[in_cnt][1] = c1; m[in_cnt][2] = c2;
          in_cnt++;
          if (in_cnt == 6) begin in_cnt = 0; have_job = 1; lat = 2; out_idx = 0; end
        end
        if (out_f) begin
          out_idx++;
          if (out_idx == 3) begin out_idx = 0; have_job = 0; i_apu_vld = 1'b0; end
        end
        if (have_job && en_s && !mute) begin
          if (lat > 0) lat--;
          else begin
            of = 1'b0;
            for (int e = 0; e < 3; e++) begin
              if (op_s == 2'd0) begin
                t[e] = {1'b0, m[out_idx][e]} + {1'b0, m[out_idx+3][e]};
                of |= t[e][32];
              end else begin
                t[e] = {1'b0, m[out_idx][e] - m[out_idx+3][e]};
                of |= (m[out_idx][e] < m[out_idx+3][e]);
              end
            end
            i_apu_vld = 1'b1; i_apu_of = of;
            i_apu_r0 = t[0][31:0]; i_apu_r1 = t[1][31:0]; i_apu_r2 = t[2][31:0];
          end
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    logic [1:0] ee;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
        if (o_rsp_vld[k]) check_output("apu_rdy_mirror", {127'd0, o_apu_rdy}, {127'd0, i_rsp_rdy[k]});
        if (o_rsp_vld[k] && i_rsp_rdy[k]) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_rsp", {126'd0, o_rsp_vld}, 128'd0);
          end else begin
            e = exp_q.pop_front();
            check_output("rsp", {27'd0, 4'(k), o_rsp_of, o_rsp_r0, o_rsp_r1, o_rsp_r2},
                                {27'd0, 4'(e.k), e.of, e.r0, e.r1, e.r2});
          end
        end
      end
      if (o_err != '0) begin
        ee = (err_q.size() > 0) ? err_q.pop_front() : 2'b00;
        check_output("err", {126'd0, o_err}, {126'd0, ee});
        check_output("en_at_err", {127'd0, o_apu_en}, 128'd0);
      end
    end
  end

  initial begin
    int n;
    bit seen;
    reset_n = 1'b0;
    #1;
    check_output("reset_ctrl", {116'd0, o_req_rdy, o_rsp_vld, o_err, o_apu_en, o_apu_op,
                                o_apu_vld, o_apu_rdy, o_rsp_of}, 128'd0);
    check_output("reset_apu_data", {32'd0, o_apu_r0, o_apu_r1, o_apu_r2}, 128'd0);
    check_output("reset_rsp_data", {32'd0, o_rsp_r0, o_rsp_r1, o_rsp_r2}, 128'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_output("idle_no_req", {124'd0, o_req_rdy, o_apu_en, o_apu_vld}, 128'd0);

    $display("[TB] contention");
    apply_stimulus(0, 2'd0, 32'd10, 32'd1, 32'd100, 32'd1);
    apply_stimulus(1, 2'd1, 32'd50, 32'd0, 32'd8, 32'd0);
    push_exp(0, 32'd110, 32'd112, 32'd114, 1'b0);
    push_exp(0, 32'd116, 32'd118, 32'd120, 1'b0);
    push_exp(0, 32'd122, 32'd124, 32'd126, 1'b0);
    push_exp(1, 32'd42, 32'd42, 32'd42, 1'b0);
    push_exp(1, 32'd42, 32'd42, 32'd42, 1'b0);
    push_exp(1, 32'd42, 32'd42, 32'd42, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = o_req_rdy[0];
    end
    check_output("req0_granted_first", {127'd0, seen}, {127'd0, 1'b1});
    check_output("req1_held_off", {126'd0, o_req_rdy}, {126'd0, 2'b01});
    wait_done(200);

    $display("[TB] fairness");
    apply_stimulus(0, 2'd0, 32'd1, 32'd1, 32'd1, 32'd0);
    apply_stimulus(0, 2'd1, 32'd7, 32'd0, 32'd7, 32'd0);
    apply_stimulus(1, 2'd0, 32'd1000, 32'd0, 32'd5, 32'd0);
    apply_stimulus(1, 2'd0, 32'd20, 32'd0, 32'd23, 32'd0);
    push_exp(0, 32'd2, 32'd3, 32'd4, 1'b0);
    push_exp(0, 32'd5, 32'd6, 32'd7, 1'b0);
    push_exp(0, 32'd8, 32'd9, 32'd10, 1'b0);
    for (int j = 0; j < 3; j++) push_exp(1, 32'd1005, 32'd1005, 32'd1005, 1'b0);
    for (int j = 0; j < 3; j++) push_exp(0, 32'd0, 32'd0, 32'd0, 1'b0);
    for (int j = 0; j < 3; j++) push_exp(1, 32'd43, 32'd43, 32'd43, 1'b0);
    wait_done(400);

    $display("[TB] single job");
    apply_stimulus(0, 2'd0, 32'd1, 32'd0, 32'd2, 32'd0);
    for (int j = 0; j < 3; j++) push_exp(0, 32'd3, 32'd3, 32'd3, 1'b0);
    wait_done(200);

    $display("[TB] backpressure");
    toggle_mode = 1'b1;
    apply_stimulus(1, 2'd0, 32'd1, 32'd1, 32'd0, 32'd0);
    push_exp(1, 32'd1, 32'd2, 32'd3, 1'b0);
    push_exp(1, 32'd4, 32'd5, 32'd6, 1'b0);
    push_exp(1, 32'd7, 32'd8, 32'd9, 1'b0);
    wait_done(200);
    toggle_mode = 1'b0;

    $display("[TB] overflow");
    apply_stimulus(0, 2'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0);
    for (int j = 0; j < 3; j++) push_exp(0, 32'd0, 32'd0, 32'd0, 1'b1);
    wait_done(200);

    $display("[TB] timeout");
    mute = 1'b1;
    apply_stimulus(1, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    err_q.push_back(2'b10);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = o_apu_en;
    end
    n = 0;
    for (int i = 0; i < 40 && o_err == '0; i++) begin
      @(negedge clk);
      n++;
    end
    check_output("timeout_cycles", 128'(n), 128'd8);
    mute = 1'b0;
    apply_stimulus(0, 2'd0, 32'd4, 32'd0, 32'd5, 32'd0);
    for (int j = 0; j < 3; j++) push_exp(0, 32'd9, 32'd9, 32'd9, 1'b0);
    wait_done(200);

    $display("[TB] reset mid-load");
    apply_stimulus(0, 2'd0, 32'd3, 32'd0, 32'd3, 32'd0);
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (o_apu_vld && i_apu_rdy) n++;
    end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_output("midreset_ctrl", {116'd0, o_req_rdy, o_rsp_vld, o_err, o_apu_en, o_apu_op,
                                   o_apu_vld, o_apu_rdy, o_rsp_of}, 128'd0);
    check_output("midreset_apu_data", {32'd0, o_apu_r0, o_apu_r1, o_apu_r2}, 128'd0);
    rq0.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    apply_stimulus(1, 2'd0, 32'd2, 32'd0, 32'd3, 32'd0);
    for (int j = 0; j < 3; j++) push_exp(1, 32'd5, 32'd5, 32'd5, 1'b0);
    wait_done(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
